issue_queue_param: RTL and testbench

- Parametrised collapsing out-of-order issue queue; next generation of the fixed 4-in/2-out queue.
- Accepts up to DISPATCH_W renamed micro-ops per cycle and holds them in age order.
- Wakes up operands from WB_W writeback tags and squashes entries on branch kill.
- Issues up to ISSUE_W oldest ready entries per cycle; adds dispatch backpressure and an occupancy count.

---
 rtl/issue_queue_param_pkg.sv | 41 ++++
 rtl/issue_queue_param_if.sv | 36 +++
 rtl/issue_queue_param_select.sv | 24 ++
 rtl/issue_queue_param.sv | 130 +++++++++++++
 tb/tb_issue_queue_param.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_param_pkg.sv
// Shared entry layout and helpers for the collapsing issue queue.
// Entry fields, MSB first: {UOP, BrM, Tag, prd, pr2, pr1, val, p2, p1}.
package iq_pkg;

  localparam int unsigned UOP_W   = 7;
  localparam int unsigned P1_POS  = 0;
  localparam int unsigned P2_POS  = 1;
  localparam int unsigned VAL_POS = 2;
  localparam int unsigned PR1_POS = 3;

  function automatic int unsigned pr2_pos(input int unsigned reg_w);
    return PR1_POS + reg_w;
  endfunction

  function automatic int unsigned prd_pos(input int unsigned reg_w);
    return PR1_POS + 2 * reg_w;
  endfunction

  function automatic int unsigned tag_pos(input int unsigned reg_w);
    return PR1_POS + 3 * reg_w;
  endfunction

  function automatic int unsigned brm_pos(input int unsigned reg_w, input int unsigned tag_w);
    return tag_pos(reg_w) + tag_w;
  endfunction

  function automatic int unsigned uop_pos(input int unsigned reg_w, input int unsigned tag_w,
                                          input int unsigned brm_w);
    return brm_pos(reg_w, tag_w) + brm_w;
  endfunction

  function automatic int unsigned iq_width(input int unsigned reg_w, input int unsigned tag_w,
                                           input int unsigned brm_w);
    return uop_pos(reg_w, tag_w, brm_w) + UOP_W;
  endfunction

  function automatic logic is_killed(input logic [31:0] brm, input logic [31:0] kill);
    return |(brm & kill);
  endfunction

endpackage

// File: rtl/issue_queue_param_if.sv
// Dispatch, writeback, kill and issue signals of the issue queue.
interface issue_queue_param_if
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DISPATCH_W = 4,
  parameter int unsigned ISSUE_W    = 2,
  parameter int unsigned WB_W       = 4,
  parameter int unsigned WIDTH_REG  = 3,
  parameter int unsigned WIDTH_TAG  = 3,
  parameter int unsigned WIDTH_BRM  = 3
);
  localparam int unsigned WIDTH = iq_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [DISPATCH_W*WIDTH-1:0] i_inst;
  logic                        i_en;
  logic                        o_disp_ready;
  logic [WB_W*WIDTH_REG-1:0]   i_wdest;
  logic [WB_W-1:0]             i_wb_valid;
  logic [WIDTH_BRM-1:0]        i_brkill;
  logic [ISSUE_W*WIDTH-1:0]    o_inst;
  logic [ISSUE_W-1:0]          o_ready;
  logic [CW-1:0]               o_count;

  modport master (
    output i_inst, i_en, i_wdest, i_wb_valid, i_brkill,
    input  o_disp_ready, o_inst, o_ready, o_count
  );

  modport slave (
    input  i_inst, i_en, i_wdest, i_wb_valid, i_brkill,
    output o_disp_ready, o_inst, o_ready, o_count
  );

endinterface

// File: rtl/issue_queue_param_select.sv
// Oldest-first picker: grant g takes the g-th lowest set bit of the candidate vector.
module iq_select #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ISSUE_W = 2
) (
  input  logic [DEPTH-1:0]              i_cand,
  output logic [ISSUE_W-1:0][DEPTH-1:0] o_gnt,
  output logic [ISSUE_W-1:0]            o_vld
);

  logic [DEPTH-1:0] w_rem;

  always_comb begin
    w_rem = i_cand;
    o_gnt = '0;
    o_vld = '0;
    for (int unsigned s = 0; s < ISSUE_W; s++) begin
      o_gnt[s] = w_rem & (~w_rem + DEPTH'(1));
      o_vld[s] = |w_rem;
      w_rem    = w_rem & ~o_gnt[s];
    end
  end

endmodule

// File: rtl/issue_queue_param.sv
// Collapsing out-of-order issue queue: age-ordered storage, tag wakeup,
// branch-mask squash, oldest-first multi-issue and dispatch backpressure.
module issue_queue_param
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DISPATCH_W = 4,
  parameter int unsigned ISSUE_W    = 2,
  parameter int unsigned WB_W       = 4,
  parameter int unsigned WIDTH_REG  = 3,
  parameter int unsigned WIDTH_TAG  = 3,
  parameter int unsigned WIDTH_BRM  = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  issue_queue_param_if.slave     bus
);

  localparam int unsigned WIDTH   = iq_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM);
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int unsigned PR2_POS = pr2_pos(WIDTH_REG);
  localparam int unsigned BRM_POS = brm_pos(WIDTH_REG, WIDTH_TAG);

  logic [DEPTH-1:0][WIDTH-1:0]      r_q;
  logic [CW-1:0]                    r_count;
  logic [DEPTH-1:0][WIDTH-1:0]      w_upd;
  logic [DEPTH-1:0][WIDTH-1:0]      w_nxt;
  logic [DISPATCH_W-1:0][WIDTH-1:0] w_in;
  logic [DEPTH-1:0]                 w_cand;
  logic [DEPTH-1:0]                 w_keep;
  logic [DEPTH-1:0]                 w_issued;
  logic [DISPATCH_W-1:0]            w_acc;
  logic [ISSUE_W-1:0][DEPTH-1:0]    w_gnt;
  logic [ISSUE_W-1:0]               w_vld;
  logic                             w_disp_ready;
  int unsigned                      w_rank  [DEPTH];
  int unsigned                      w_irank [DISPATCH_W];
  int unsigned                      w_total;

  function automatic logic wb_hit(input logic [WIDTH_REG-1:0]      pr,
                                  input logic [WB_W*WIDTH_REG-1:0] wdest,
                                  input logic [WB_W-1:0]           wv);
    logic hit;
    hit = 1'b0;
    for (int unsigned w = 0; w < WB_W; w++)
      if (wv[w] && wdest[w*WIDTH_REG +: WIDTH_REG] == pr) hit = 1'b1;
    return hit;
  endfunction

  assign w_disp_ready = r_count <= CW'(DEPTH - DISPATCH_W);

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic w_kill, w_h1, w_h2;
      assign w_kill    = is_killed(32'(r_q[i][BRM_POS +: WIDTH_BRM]), 32'(bus.i_brkill));
      assign w_h1      = wb_hit(r_q[i][PR1_POS +: WIDTH_REG], bus.i_wdest, bus.i_wb_valid);
      assign w_h2      = wb_hit(r_q[i][PR2_POS +: WIDTH_REG], bus.i_wdest, bus.i_wb_valid);
      // Candidacy uses the registered p bits; this cycle's wakeup only lands in w_upd.
      assign w_cand[i] = r_q[i][VAL_POS] & r_q[i][P1_POS] & r_q[i][P2_POS] & ~w_kill;
      assign w_keep[i] = r_q[i][VAL_POS] & ~w_kill & ~w_issued[i];
      assign w_upd[i]  = r_q[i] | (WIDTH'(w_h1) << P1_POS) | (WIDTH'(w_h2) << P2_POS);
    end

    for (genvar k = 0; k < DISPATCH_W; k++) begin : g_in
      logic [WIDTH-1:0] w_slot;
      logic             w_kill, w_h1, w_h2;
      assign w_slot   = bus.i_inst[k*WIDTH +: WIDTH];
      assign w_kill   = is_killed(32'(w_slot[BRM_POS +: WIDTH_BRM]), 32'(bus.i_brkill));
      assign w_h1     = wb_hit(w_slot[PR1_POS +: WIDTH_REG], bus.i_wdest, bus.i_wb_valid);
      assign w_h2     = wb_hit(w_slot[PR2_POS +: WIDTH_REG], bus.i_wdest, bus.i_wb_valid);
      assign w_in[k]  = w_slot | (WIDTH'(w_h1) << P1_POS) | (WIDTH'(w_h2) << P2_POS);
      assign w_acc[k] = bus.i_en & w_disp_ready & w_slot[VAL_POS] & ~w_kill;
    end
  endgenerate

  iq_select #(
    .DEPTH   (DEPTH),
    .ISSUE_W (ISSUE_W)
  ) u_select (
    .i_cand (w_cand),
    .o_gnt  (w_gnt),
    .o_vld  (w_vld)
  );

  always_comb begin
    w_issued   = '0;
    bus.o_inst = '0;
    for (int unsigned s = 0; s < ISSUE_W; s++) begin
      w_issued = w_issued | w_gnt[s];
      for (int unsigned i = 0; i < DEPTH; i++)
        if (w_gnt[s][i]) bus.o_inst[s*WIDTH +: WIDTH] = r_q[i];
    end
  end

  assign bus.o_ready      = w_vld;
  assign bus.o_count      = r_count;
  assign bus.o_disp_ready = w_disp_ready;

  // Each survivor/accepted slot lands at its rank, i.e. the count of
  // survivors/accepted slots ahead of it; this both compacts and appends.
  always_comb begin
    w_total = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_rank[i] = w_total;
      if (w_keep[i]) w_total = w_total + 1;
    end
    for (int unsigned k = 0; k < DISPATCH_W; k++) begin
      w_irank[k] = w_total;
      if (w_acc[k]) w_total = w_total + 1;
    end
    w_nxt = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (w_keep[i] && w_rank[i] == j) w_nxt[j] = w_upd[i];
      for (int unsigned k = 0; k < DISPATCH_W; k++)
        if (w_acc[k] && w_irank[k] == j) w_nxt[j] = w_in[k];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q     <= '0;
      r_count <= '0;
    end else begin
      r_q     <= w_nxt;
      r_count <= CW'(w_total);
    end
  end

endmodule

// File: tb/tb_issue_queue_param.sv
// Directed bench for issue_queue_param with a queue-based reference model checked every cycle.
module tb_issue_queue_param;

  localparam int W = 25;

  typedef struct packed {
    logic [6:0] uop;
    logic [2:0] brm;
    logic [2:0] tag;
    logic [2:0] prd;
    logic [2:0] pr2;
    logic [2:0] pr1;
    logic       v;
    logic       p2;
    logic       p1;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  issue_queue_param_if #(
    .DEPTH(8), .DISPATCH_W(4), .ISSUE_W(2), .WB_W(4),
    .WIDTH_REG(3), .WIDTH_TAG(3), .WIDTH_BRM(3)
  ) bus ();

  issue_queue_param #(
    .DEPTH(8), .DISPATCH_W(4), .ISSUE_W(2), .WB_W(4),
    .WIDTH_REG(3), .WIDTH_TAG(3), .WIDTH_BRM(3)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t q[$];
  ent_t Z = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input int exp);
    check(nm, 64'(bus.o_count), 64'(exp));
  endtask
  task automatic chk_rdy(input string nm, input logic [1:0] exp);
    check(nm, 64'(bus.o_ready), 64'(exp));
  endtask
  task automatic chk_dr(input string nm, input logic exp);
    check(nm, 64'(bus.o_disp_ready), 64'(exp));
  endtask
  task automatic chk_slot(input string nm, input int s, input ent_t exp);
    check(nm, 64'(bus.o_inst[s*W +: W]), 64'(exp));
  endtask

  function automatic ent_t mk(input logic [6:0] uop, input logic [2:0] brm,
                              input logic [2:0] pr1, input logic [2:0] pr2,
                              input logic p1, input logic p2);
    ent_t e;
    e.uop = uop; e.brm = brm; e.tag = uop[2:0]; e.prd = ~uop[2:0];
    e.pr2 = pr2; e.pr1 = pr1; e.v = 1'b1; e.p2 = p2; e.p1 = p1;
    return e;
  endfunction

  function automatic logic hit(input logic [2:0] pr);
    for (int w = 0; w < 4; w++)
      if (bus.i_wb_valid[w] && bus.i_wdest[w*3 +: 3] == pr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic killed(input ent_t e);
    return (e.brm & bus.i_brkill) != 3'b000;
  endfunction

  // Reference model: an age-ordered list of resident micro-ops.
  task automatic model_step();
    ent_t nq[$];
    ent_t e;
    int   n;
    logic acc;
    n   = 0;
    acc = bus.i_en && ((8 - q.size()) >= 4);
    foreach (q[i]) begin
      e = q[i];
      if (killed(e)) continue;
      if (n < 2 && e.p1 && e.p2) begin
        n++;
        continue;
      end
      e.p1 = e.p1 | hit(e.pr1);
      e.p2 = e.p2 | hit(e.pr2);
      nq.push_back(e);
    end
    if (acc) begin
      for (int k = 0; k < 4; k++) begin
        e = bus.i_inst[k*W +: W];
        if (e.v && !killed(e)) begin
          e.p1 = e.p1 | hit(e.pr1);
          e.p2 = e.p2 | hit(e.pr2);
          nq.push_back(e);
        end
      end
    end
    q = nq;
  endtask

  initial begin
    logic [2*W-1:0] ei;
    logic [1:0]     er;
    int             n;
    forever begin
      @(negedge clk);
      if (rst) q.delete();
      ei = '0;
      er = '0;
      n  = 0;
      foreach (q[i]) begin
        if (n < 2 && q[i].p1 && q[i].p2 && !killed(q[i])) begin
          ei[n*W +: W] = q[i];
          er[n]        = 1'b1;
          n++;
        end
      end
      check("m_ready", 64'(bus.o_ready), 64'(er));
      check("m_inst", 64'(bus.o_inst), 64'(ei));
      check("m_count", 64'(bus.o_count), 64'(q.size()));
      check("m_disp_ready", 64'(bus.o_disp_ready), 64'((8 - q.size()) >= 4));
      @(posedge clk);
      if (rst) q.delete();
      else     model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_inst     = '0;
    bus.i_en       = 1'b0;
    bus.i_wdest    = '0;
    bus.i_wb_valid = '0;
    bus.i_brkill   = '0;
  endtask

  task automatic disp(input ent_t s0, input ent_t s1, input ent_t s2, input ent_t s3);
    bus.i_inst = {s3, s2, s1, s0};
    bus.i_en   = 1'b1;
  endtask

  initial begin
    ent_t a[4], k[6], f[5], g[4], h[4];
    ent_t e, e2, b, c0, c1, t;
    for (int i = 0; i < 4; i++) a[i] = mk(7'(8'h11 + i), 3'b000, 3'h0, 3'h0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) k[i] = mk(7'(8'h30 + i), (i % 2 == 1) ? 3'b001 : 3'b010, 3'h7, 3'h0, 1'b0, 1'b1);
    f[0] = mk(7'h40, 3'b000, 3'h1, 3'h0, 1'b0, 1'b1);
    for (int i = 1; i < 5; i++) f[i] = mk(7'(8'h40 + i), 3'b000, 3'h2, 3'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) g[i] = mk(7'(8'h50 + i), 3'b000, 3'h0, 3'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) h[i] = mk(7'(8'h60 + i), 3'b000, 3'h2, 3'h0, 1'b0, 1'b1);
    e  = mk(7'h21, 3'b000, 3'h6, 3'h0, 1'b0, 1'b1);
    e2 = mk(7'h22, 3'b100, 3'h6, 3'h0, 1'b0, 1'b1);
    b  = mk(7'h70, 3'b000, 3'h0, 3'h5, 1'b1, 1'b0);
    c0 = mk(7'h71, 3'b100, 3'h0, 3'h0, 1'b1, 1'b1);
    c1 = mk(7'h72, 3'b000, 3'h0, 3'h0, 1'b1, 1'b1);

    idle();
    repeat (2) tick();
    chk_cnt("rst_cnt", 0);
    chk_rdy("rst_rdy", 2'b00);
    chk_dr("rst_dr", 1'b1);
    rst = 1'b0;
    tick();

    // four ready entries, issued two per cycle oldest first
    disp(a[0], a[1], a[2], a[3]);
    #1 chk_dr("t1_dr", 1'b1);
    tick(); idle(); #1;
    chk_cnt("t1_cnt4", 4);
    chk_rdy("t1_rdy_a", 2'b11);
    chk_slot("t1_s0_a", 0, a[0]);
    chk_slot("t1_s1_a", 1, a[1]);
    tick(); #1;
    chk_cnt("t1_cnt2", 2);
    chk_rdy("t1_rdy_b", 2'b11);
    chk_slot("t1_s0_b", 0, a[2]);
    chk_slot("t1_s1_b", 1, a[3]);
    tick(); #1;
    chk_cnt("t1_cnt0", 0);
    chk_rdy("t1_rdy_c", 2'b00);

    // registered wakeup through port 2
    disp(e, Z, Z, Z);
    tick(); idle();
    bus.i_wdest    = {3'h0, 3'h6, 3'h0, 3'h0};
    bus.i_wb_valid = 4'b0100;
    #1 chk_rdy("t2_wake_cycle", 2'b00);
    chk_cnt("t2_cnt1", 1);
    tick(); idle(); #1;
    chk_rdy("t2_issue", 2'b01);
    t = e; t.p1 = 1'b1;
    chk_slot("t2_s0", 0, t);
    tick(); #1 chk_cnt("t2_cnt0", 0);

    // same tag on the bus but no valid: never issues, then squashed
    disp(e2, Z, Z, Z);
    tick(); idle();
    bus.i_wdest = {3'h0, 3'h6, 3'h0, 3'h0};
    repeat (3) begin
      #1 chk_rdy("t2_nowb", 2'b00);
      tick();
    end
    chk_cnt("t2_nowb_cnt", 1);
    bus.i_brkill = 3'b100;
    #1 chk_rdy("t2_kill_rdy", 2'b00);
    tick(); idle(); #1 chk_cnt("t2_kill_cnt", 0);

    // branch kill of alternating masks, survivors keep order
    disp(k[0], k[1], k[2], k[3]);
    tick();
    disp(k[4], k[5], Z, Z);
    tick(); idle(); #1 chk_cnt("t3_cnt6", 6);
    bus.i_brkill = 3'b010;
    #1 chk_rdy("t3_kill_rdy", 2'b00);
    tick(); idle(); #1 chk_cnt("t3_cnt3", 3);
    bus.i_wdest    = {3'h0, 3'h0, 3'h0, 3'h7};
    bus.i_wb_valid = 4'b0001;
    tick(); idle(); #1;
    chk_rdy("t3_rdy_a", 2'b11);
    t = k[1]; t.p1 = 1'b1; chk_slot("t3_s0_a", 0, t);
    t = k[3]; t.p1 = 1'b1; chk_slot("t3_s1_a", 1, t);
    tick(); #1;
    chk_rdy("t3_rdy_b", 2'b01);
    t = k[5]; t.p1 = 1'b1; chk_slot("t3_s0_b", 0, t);
    chk_cnt("t3_cnt1", 1);
    tick(); #1 chk_cnt("t3_cnt0", 0);

    // backpressure at 5 entries, release by one issue, fill to 8
    disp(f[0], f[1], f[2], f[3]);
    tick();
    disp(f[4], Z, Z, Z);
    tick(); idle(); #1;
    chk_cnt("t4_cnt5", 5);
    chk_dr("t4_dr0", 1'b0);
    disp(g[0], g[1], g[2], g[3]);
    #1 chk_dr("t4_dr0_en", 1'b0);
    tick(); idle(); #1;
    chk_cnt("t4_ignored", 5);
    chk_rdy("t4_rdy0", 2'b00);
    bus.i_wdest    = {3'h0, 3'h0, 3'h1, 3'h0};
    bus.i_wb_valid = 4'b0010;
    tick(); idle(); #1;
    chk_rdy("t4_rdy_f0", 2'b01);
    t = f[0]; t.p1 = 1'b1; chk_slot("t4_s0_f0", 0, t);
    chk_dr("t4_dr_still0", 1'b0);
    tick(); #1;
    chk_cnt("t4_cnt4", 4);
    chk_dr("t4_dr1", 1'b1);
    disp(h[0], h[1], h[2], h[3]);
    tick(); idle(); #1;
    chk_cnt("t4_cnt8", 8);
    chk_dr("t4_dr_full", 1'b0);
    bus.i_wdest    = {3'h0, 3'h0, 3'h0, 3'h2};
    bus.i_wb_valid = 4'b0001;
    tick(); idle(); #1;
    chk_rdy("t4_drain_rdy", 2'b11);
    repeat (4) tick();
    #1 chk_cnt("t4_drained", 0);

    // same-cycle bypass wakeup on dispatch
    disp(b, Z, Z, Z);
    bus.i_wdest    = {3'h0, 3'h0, 3'h0, 3'h5};
    bus.i_wb_valid = 4'b0001;
    tick(); idle(); #1;
    chk_rdy("t5_rdy", 2'b01);
    t = b; t.p2 = 1'b1; chk_slot("t5_s0", 0, t);
    tick(); #1 chk_cnt("t5_cnt0", 0);

    // kill beats issue for an otherwise ready entry
    disp(c0, c1, Z, Z);
    tick(); idle();
    bus.i_brkill = 3'b100;
    #1;
    chk_rdy("t6_rdy", 2'b01);
    chk_slot("t6_s0", 0, c1);
    chk_slot("t6_s1", 1, Z);
    tick(); idle(); #1 chk_cnt("t6_cnt0", 0);

    // asynchronous reset mid-cycle with 5 resident entries
    disp(f[0], f[1], f[2], f[3]);
    tick();
    disp(f[4], Z, Z, Z);
    tick(); idle(); #1 chk_cnt("t7_cnt5", 5);
    #1 rst = 1'b1;
    #1;
    chk_cnt("t7_rst_cnt", 0);
    chk_rdy("t7_rst_rdy", 2'b00);
    chk_dr("t7_rst_dr", 1'b1);
    check("t7_rst_inst", 64'(bus.o_inst), 64'h0);
    tick();
    rst = 1'b0;
    tick(); #1 chk_cnt("t7_post_cnt", 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
